mem_store_aligner: RTL

Parametrised store-path data encoder for the MIPS32 SOC data memory port, succeeding the combinational write-data encoder. It takes store requests (address, data, size) over a valid/ready handshake, places the data on the correct big-endian byte lanes, and generates byte write-enables. Outputs are registered and held under memory backpressure. Misaligned stores that cross a bus-word boundary can optionally be split into two bus beats.

---
 rtl/mem_store_pkg.sv | 24 ++
 rtl/mem_lane_encoder.sv | 45 ++++
 rtl/mem_store_aligner.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mem_store_pkg.sv
// rtl/mem_store_pkg.sv - size encodings, FSM state type and size helper for mem_store_aligner
package mem_store_pkg;

    localparam logic [1:0] SZ_WORD  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_BYTE  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BEAT0 = 2'b01,
        BEAT1 = 2'b10
    } state_t;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_WORD: size_bytes = 4'd4;
            SZ_HALF: size_bytes = 4'd2;
            SZ_BYTE: size_bytes = 4'd1;
            default: size_bytes = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_encoder.sv
// rtl/mem_lane_encoder.sv - big-endian lane placement and byte enables for one store beat
// Split behaviour selected by MEM_STORE_SPLIT_EN; otherwise offsets truncate to natural alignment.
module mem_lane_encoder
    import mem_store_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int BYTES = DATA_W / 8,
    localparam int OFS_W = $clog2(BYTES)
) (
    input  logic [DATA_W-1:0] data,
    input  logic [OFS_W-1:0]  offset,
    input  logic [1:0]        size,
    input  logic              beat,
    output logic [DATA_W-1:0] lane_data,
    output logic [BYTES-1:0]  lane_we,
    output logic              split
);

    always_comb begin
        int s;
        int o;
        int p;
        int b;
        lane_data = '0;
        lane_we   = '0;
        split     = 1'b0;
        s = int'(size_bytes(size));
        o = int'(offset);
`ifdef MEM_STORE_SPLIT_EN
        split = (o + s) > BYTES;
`else
        o = o & ~(s - 1);
`endif
        // p is the element byte (0 = MSB) that lands on lane k in this beat
        for (int k = 0; k < BYTES; k++) begin
            p = beat ? (k + BYTES - o) : (k - o);
            b = s - 1 - p;
            if (p >= 0 && p < s && b < BYTES) begin
                lane_data[DATA_W-1-8*k -: 8] = data[8*b +: 8];
                lane_we[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_store_aligner.sv
// rtl/mem_store_aligner.sv - registered store-path encoder with valid/ready handshake
// Optional split of bus-word-crossing stores under MEM_STORE_SPLIT_EN.
module mem_store_aligner
    import mem_store_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_data,
    input  logic [1:0]          req_size,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_we,
    output logic                err
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFS_W = $clog2(BYTES);

    state_t              state;
    logic                done;
    logic                final_beat;
    logic                accept;
    logic                illegal;
    logic                split_pending;
    logic                enc_split;
    logic                enc_beat;
    logic [DATA_W-1:0]   enc_in_data;
    logic [OFS_W-1:0]    enc_in_ofs;
    logic [1:0]          enc_in_size;
    logic [DATA_W-1:0]   enc_data;
    logic [BYTES-1:0]    enc_we;
    logic [ADDR_W-1:0]   req_base;

    assign illegal    = (req_size == SZ_DWORD) && (DATA_W == 32);
    assign req_base   = {req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
    assign done       = mem_valid && mem_ready;
    assign final_beat = (state == BEAT1) || !split_pending;
    assign req_ready  = (state == IDLE) || (done && final_beat);
    assign accept     = req_valid && req_ready;

`ifdef MEM_STORE_SPLIT_EN
    logic [DATA_W-1:0] hold_data;
    logic [OFS_W-1:0]  hold_ofs;
    logic [1:0]        hold_size;
    logic              sel_beat1;

    // While beat 0 of a split is out, no request can be accepted, so the
    // encoder is free to precompute beat 1 from the held request.
    assign sel_beat1   = (state == BEAT0) && split_pending;
    assign enc_beat    = sel_beat1;
    assign enc_in_data = sel_beat1 ? hold_data : req_data;
    assign enc_in_ofs  = sel_beat1 ? hold_ofs  : req_addr[OFS_W-1:0];
    assign enc_in_size = sel_beat1 ? hold_size : req_size;
`else
    assign enc_beat    = 1'b0;
    assign enc_in_data = req_data;
    assign enc_in_ofs  = req_addr[OFS_W-1:0];
    assign enc_in_size = req_size;
`endif

    mem_lane_encoder #(.DATA_W(DATA_W)) u_enc (
        .data      (enc_in_data),
        .offset    (enc_in_ofs),
        .size      (enc_in_size),
        .beat      (enc_beat),
        .lane_data (enc_data),
        .lane_we   (enc_we),
        .split     (enc_split)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            mem_valid     <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_we        <= '0;
            err           <= 1'b0;
            split_pending <= 1'b0;
`ifdef MEM_STORE_SPLIT_EN
            hold_data     <= '0;
            hold_ofs      <= '0;
            hold_size     <= '0;
`endif
        end else begin
            err <= 1'b0;
`ifdef MEM_STORE_SPLIT_EN
            if (sel_beat1 && done) begin
                state     <= BEAT1;
                mem_addr  <= mem_addr + ADDR_W'(BYTES);
                mem_wdata <= enc_data;
                mem_we    <= enc_we;
            end else
`endif
            if (accept) begin
                if (illegal) begin
                    err       <= 1'b1;
                    mem_valid <= 1'b0;
                    state     <= IDLE;
                end else begin
                    state         <= BEAT0;
                    mem_valid     <= 1'b1;
                    mem_addr      <= req_base;
                    mem_wdata     <= enc_data;
                    mem_we        <= enc_we;
                    split_pending <= enc_split;
`ifdef MEM_STORE_SPLIT_EN
                    hold_data     <= req_data;
                    hold_ofs      <= req_addr[OFS_W-1:0];
                    hold_size     <= req_size;
`endif
                end
            end else if (done) begin
                state     <= IDLE;
                mem_valid <= 1'b0;
            end
        end
    end

endmodule
